// File: rtl/nms_window_gen.sv
// 3x3 magnitude/direction window producer feeding non-max suppression.
// Define NMS_WIN_DIR_SANITIZE_EN to zero illegal directions and expose dir_err.
module nms_window_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_sof,
  input  logic [7:0]  pix_mag,
  input  logic [7:0]  pix_dir,
  input  logic        pix_valid,
  output logic [71:0] mag_data,
  output logic        mag_data_valid,
  output logic [71:0] dir_data,
  output logic        dir_data_valid,
  output logic        frame_done
`ifdef NMS_WIN_DIR_SANITIZE_EN
  ,
  output logic        dir_err
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    PRIME,
    STREAM,
    FRAME_END
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [71:0]   win_mag_q, win_mag_d;
  logic [71:0]   win_dir_q, win_dir_d;
  logic [71:0]   mag_data_q, mag_data_d;
  logic [71:0]   dir_data_q, dir_data_d;
  logic          valid_q, valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0] lb1_mag [IMG_WIDTH];
  logic [7:0] lb2_mag [IMG_WIDTH];
  logic [7:0] lb1_dir [IMG_WIDTH];
  logic [7:0] lb2_dir [IMG_WIDTH];

  logic          run;
  logic          start;
  logic          adv;
  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic          col_last;
  logic          row_last;
  logic [7:0]    dir_in;
  logic [7:0]    top_mag, mid_mag;
  logic [7:0]    top_dir, mid_dir;

  assign run      = (state_q == PRIME) || (state_q == STREAM);
  assign start    = pix_valid && pix_sof && (state_q != FRAME_END);
  assign adv      = pix_valid && !pix_sof && run;
  assign wr_en    = start || adv;
  assign wr_addr  = start ? '0 : col_q;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  assign top_mag = lb2_mag[wr_addr];
  assign mid_mag = lb1_mag[wr_addr];
  assign top_dir = lb2_dir[wr_addr];
  assign mid_dir = lb1_dir[wr_addr];

`ifdef NMS_WIN_DIR_SANITIZE_EN
  logic dir_bad;
  logic dir_err_q, dir_err_d;

  assign dir_bad   = (pix_dir < 8'd1) || (pix_dir > 8'd4);
  assign dir_in    = dir_bad ? 8'd0 : pix_dir;
  assign dir_err_d = dir_err_q || (wr_en && dir_bad);
  assign dir_err   = dir_err_q;

  always_ff @(posedge clk) begin
    if (rst) dir_err_q <= 1'b0;
    else     dir_err_q <= dir_err_d;
  end
`else
  assign dir_in = pix_dir;
`endif

  // Each row shifts left by one column; new column enters on the right.
  function automatic logic [71:0] win_shift(
    input logic [71:0] w,
    input logic [7:0]  top,
    input logic [7:0]  mid,
    input logic [7:0]  bot
  );
    return {w[63:48], bot, w[39:24], mid, w[15:0], top};
  endfunction

  // Read-before-write: line r-1 slot moves down to the r-2 buffer.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      lb2_mag[wr_addr] <= lb1_mag[wr_addr];
      lb1_mag[wr_addr] <= pix_mag;
      lb2_dir[wr_addr] <= lb1_dir[wr_addr];
      lb1_dir[wr_addr] <= dir_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_mag_d    = win_mag_q;
    win_dir_d    = win_dir_q;
    mag_data_d   = mag_data_q;
    dir_data_d   = dir_data_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;

    if (wr_en) begin
      win_mag_d = win_shift(win_mag_q, top_mag, mid_mag, pix_mag);
      win_dir_d = win_shift(win_dir_q, top_dir, mid_dir, dir_in);
    end

    if (start) begin
      col_d   = CW'(1);
      row_d   = '0;
      state_d = PRIME;
    end else if (adv) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      unique case (state_q)
        PRIME: begin
          if (row_q == RW'(1) && col_last) state_d = STREAM;
        end
        STREAM: begin
          if (col_q >= CW'(2)) begin
            valid_d    = 1'b1;
            mag_data_d = win_mag_d;
            dir_data_d = win_dir_d;
          end
          if (row_last && col_last) begin
            state_d      = FRAME_END;
            frame_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state_q == FRAME_END) begin
      state_d = WAIT_SOF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      win_mag_q    <= '0;
      win_dir_q    <= '0;
      mag_data_q   <= '0;
      dir_data_q   <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_mag_q    <= win_mag_d;
      win_dir_q    <= win_dir_d;
      mag_data_q   <= mag_data_d;
      dir_data_q   <= dir_data_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mag_data       = mag_data_q;
  assign dir_data       = dir_data_q;
  assign mag_data_valid = valid_q;
  assign dir_data_valid = valid_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_nms_window_gen.sv
// Bench for nms_window_gen: raster-index reference model, directed
// scenarios plus randomized streams on a 5x4 image.
module tb_nms_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_mag = '0;
  logic [7:0]  pix_dir = '0;
  logic        pix_valid = 1'b0;
  logic [71:0] mag_data;
  logic        mag_data_valid;
  logic [71:0] dir_data;
  logic        dir_data_valid;
  logic        frame_done;
`ifdef NMS_WIN_DIR_SANITIZE_EN
  logic        dir_err;
`endif

  nms_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_sof       (pix_sof),
    .pix_mag       (pix_mag),
    .pix_dir       (pix_dir),
    .pix_valid     (pix_valid),
    .mag_data      (mag_data),
    .mag_data_valid(mag_data_valid),
    .dir_data      (dir_data),
    .dir_data_valid(dir_data_valid),
    .frame_done    (frame_done)
`ifdef NMS_WIN_DIR_SANITIZE_EN
    ,
    .dir_err       (dir_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame image indexed by raster position.
  int          mode = 0;
  int          p = 0;
  logic [7:0]  img_m [W*H];
  logic [7:0]  img_d [W*H];
  logic        ev = 1'b0;
  logic        efd = 1'b0;
  logic        eerr = 1'b0;
  logic [71:0] emag = '0;
  logic [71:0] edir = '0;

  int          nwin = 0;
  logic [71:0] first_mag = '0;
  logic [71:0] first_dir = '0;
  logic [71:0] last_mag = '0;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] build(input bit is_dir, input int r,
                                        input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int idx;
        idx = (r - 2 + i) * W + (c - 2 + j);
        w[i*24 + (2-j)*8 +: 8] = is_dir ? img_d[idx] : img_m[idx];
      end
    return w;
  endfunction

  task automatic model(input logic v, input logic s,
                       input logic [7:0] m, input logic [7:0] d);
    logic [7:0] ds;
    logic       acc;
    ds  = d;
    acc = 1'b0;
`ifdef NMS_WIN_DIR_SANITIZE_EN
    if (d < 8'd1 || d > 8'd4) ds = 8'd0;
`endif
    ev  = 1'b0;
    efd = 1'b0;
    if (mode == 2) begin
      mode = 0;
    end else if (v && s) begin
      p = 0; img_m[0] = m; img_d[0] = ds; mode = 1; acc = 1'b1;
    end else if (v && mode == 1) begin
      p++;
      img_m[p] = m; img_d[p] = ds; acc = 1'b1;
      if (p / W >= 2 && p % W >= 2) begin
        ev   = 1'b1;
        emag = build(1'b0, p / W, p % W);
        edir = build(1'b1, p / W, p % W);
      end
      if (p == W*H - 1) begin
        efd  = 1'b1;
        mode = 2;
      end
    end
`ifdef NMS_WIN_DIR_SANITIZE_EN
    if (acc && ds != d) eerr = 1'b1;
`else
    if (acc) eerr = 1'b0;
`endif
  endtask

  task automatic check_outs();
    chk("valid", 72'(mag_data_valid), 72'(ev));
    chk("dvalid", 72'(dir_data_valid), 72'(ev));
    chk("fdone", 72'(frame_done), 72'(efd));
    chk("mag", mag_data, emag);
    chk("dir", dir_data, edir);
`ifdef NMS_WIN_DIR_SANITIZE_EN
    chk("derr", 72'(dir_err), 72'(eerr));
`endif
    if (mag_data_valid) begin
      nwin++;
      if (nwin == 1) begin
        first_mag = mag_data;
        first_dir = dir_data;
      end
      last_mag = mag_data;
    end
  endtask

  task automatic step(input logic v, input logic s,
                      input logic [7:0] m, input logic [7:0] d);
    pix_valid = v; pix_sof = s; pix_mag = m; pix_dir = d;
    model(v, s, m, d);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1;
    pix_mag = 8'hff; pix_dir = 8'd9;
    mode = 0; p = 0; ev = 1'b0; efd = 1'b0; eerr = 1'b0;
    emag = '0; edir = '0;
    @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  // Directed frame: mag = raster index, dir = 1 except at bad_at.
  task automatic send_frame(input bit gaps, input int bad_at);
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, i == 0, 8'(i), (i == bad_at) ? 8'd7 : 8'd1);
      if (gaps) step(1'b0, 1'b0, 8'hee, 8'd3);
    end
    step(1'b1, 1'b0, 8'hdd, 8'd2);
    step(1'b0, 1'b0, 8'h00, 8'd0);
  endtask

  initial begin
    do_reset();

    nwin = 0;
    send_frame(1'b0, -1);
    chk("win_cnt_cont", 72'(nwin), 72'd6);
    chk("first_win", first_mag, 72'h0a0b0c_050607_000102);
    chk("last_ctr", 72'(last_mag[39:32]), 72'd13);

    nwin = 0;
    send_frame(1'b1, -1);
    chk("win_cnt_gaps", 72'(nwin), 72'd6);
    chk("first_win_gaps", first_mag, 72'h0a0b0c_050607_000102);

    nwin = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(i + 40), 8'd1);
    chk("win_cnt_nosof", 72'(nwin), 72'd0);
    send_frame(1'b0, -1);
    chk("win_cnt_after_nosof", 72'(nwin), 72'd6);

    for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'(i + 100), 8'd4);
    do_reset();
    nwin = 0;
    send_frame(1'b0, -1);
    chk("win_cnt_post_rst", 72'(nwin), 72'd6);
    chk("first_win_post_rst", first_mag, 72'h0a0b0c_050607_000102);

    nwin = 0;
    for (int i = 0; i < 11; i++) step(1'b1, i == 0, 8'(i + 60), 8'd3);
    for (int i = 0; i < W*H; i++) step(1'b1, i == 0, 8'(i), 8'd1);
    step(1'b0, 1'b0, 8'h00, 8'd0);
    chk("win_cnt_resync", 72'(nwin), 72'd6);
    chk("first_win_resync", first_mag, 72'h0a0b0c_050607_000102);

    nwin = 0;
    send_frame(1'b0, W + 1);
`ifdef NMS_WIN_DIR_SANITIZE_EN
    chk("ctr_dir_bad", 72'(first_dir[39:32]), 72'd0);
    chk("dir_err_sticky", 72'(dir_err), 72'd1);
`else
    chk("ctr_dir_bad", 72'(first_dir[39:32]), 72'd7);
`endif

    for (int i = 0; i < 1500; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (mode == 0) ? ($urandom_range(0, 2) == 0)
                      : ($urandom_range(0, 80) == 0);
      step(v, s, 8'($urandom), 8'($urandom_range(0, 7)));
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
